// File: rtl/dkong_ram_arb_pkg.sv
// dkong_ram_arb_pkg: shared FSM state, requester indices and grant type for the work-RAM arbiter
package dkong_ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAITQ} state_t;
  localparam int REQ_DMA = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_HS  = 2;
  typedef logic [2:0] grant_t;
endpackage

// File: rtl/dkong_ram_arb_pick.sv
// dkong_ram_arb_pick: one-hot winner select, DMA > CPU > HS, or DMA > HS > CPU when promote is set
module dkong_ram_arb_pick
  import dkong_ram_arb_pkg::*;
(
  input  grant_t req,
  input  logic   promote,
  output grant_t grant
);
  localparam grant_t G_DMA = grant_t'(1 << REQ_DMA);
  localparam grant_t G_CPU = grant_t'(1 << REQ_CPU);
  localparam grant_t G_HS  = grant_t'(1 << REQ_HS);
  always_comb begin
    grant = req[REQ_DMA]              ? G_DMA :
            (promote && req[REQ_HS])  ? G_HS  :
            req[REQ_CPU]              ? G_CPU :
            req[REQ_HS]               ? G_HS  : '0;
  end
endmodule

// File: rtl/dkong_ram_arb.sv
// dkong_ram_arb: single-port work-RAM arbiter/sequencer for DMA, CPU and hiscore requesters.
// Define DKONG_RAM_ARB_STARVE_EN to promote HS above CPU after HS_MAX_WAIT CPU grants.
module dkong_ram_arb
  import dkong_ram_arb_pkg::*;
#(
  parameter int AW          = 10,
  parameter int DW          = 8,
  parameter int HS_MAX_WAIT = 4
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_DMA_REQ,
  input  logic [AW-1:0] I_DMA_A,
  output logic          O_DMA_ACK,
  input  logic          I_CPU_REQ,
  input  logic          I_CPU_WE,
  input  logic [AW-1:0] I_CPU_A,
  input  logic [DW-1:0] I_CPU_D,
  output logic          O_CPU_ACK,
  output logic          O_CPU_WAITn,
  input  logic          I_HS_REQ,
  input  logic          I_HS_WE,
  input  logic [AW-1:0] I_HS_A,
  input  logic [DW-1:0] I_HS_D,
  output logic          O_HS_ACK,
  output logic [DW-1:0] O_RD_D,
  output logic [AW-1:0] O_RAM_A,
  output logic          O_RAM_CE,
  output logic          O_RAM_WE,
  output logic [DW-1:0] O_RAM_D,
  input  logic [DW-1:0] I_RAM_Q
);
  state_t state, state_nx;
  grant_t gnt, pick, req_m, ack;
  logic   promote, we_r, grant_now;
  // the requester being acked this cycle is masked so a held REQ cannot be granted twice
  assign req_m = {I_HS_REQ & ~ack[REQ_HS], I_CPU_REQ & ~ack[REQ_CPU], I_DMA_REQ & ~ack[REQ_DMA]};
  dkong_ram_arb_pick u_pick (.req(req_m), .promote(promote), .grant(pick));
  assign grant_now = (state == IDLE) && (|pick);
  always_comb begin
    state_nx = (state == IDLE)  ? (grant_now ? ISSUE : IDLE) :
               (state == ISSUE) ? WAITQ : IDLE;
  end
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      we_r    <= 1'b0;
      O_RAM_A <= '0;
      O_RAM_D <= '0;
      O_RD_D  <= '0;
    end else begin
      state <= state_nx;
      ack   <= (state == WAITQ) ? gnt : '0;
      if (state == WAITQ && !we_r) O_RD_D <= I_RAM_Q;
      if (grant_now) begin
        gnt     <= pick;
        we_r    <= pick[REQ_CPU] ? I_CPU_WE : pick[REQ_HS] ? I_HS_WE : 1'b0;
        O_RAM_A <= pick[REQ_DMA] ? I_DMA_A : pick[REQ_CPU] ? I_CPU_A : I_HS_A;
        O_RAM_D <= pick[REQ_CPU] ? I_CPU_D : pick[REQ_HS] ? I_HS_D : '0;
      end
    end
  end
`ifdef DKONG_RAM_ARB_STARVE_EN
  localparam logic [3:0] HS_MAX = 4'(HS_MAX_WAIT);
  logic [3:0] hs_skip;
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) hs_skip <= '0;
    else if (grant_now && pick[REQ_HS]) hs_skip <= '0;
    else if (grant_now && pick[REQ_CPU] && I_HS_REQ && hs_skip != HS_MAX) hs_skip <= hs_skip + 4'd1;
  end
  assign promote = (hs_skip == HS_MAX);
`else
  assign promote = 1'b0;
`endif
  assign O_RAM_CE    = (state == ISSUE);
  assign O_RAM_WE    = O_RAM_CE & we_r;
  assign O_DMA_ACK   = ack[REQ_DMA];
  assign O_CPU_ACK   = ack[REQ_CPU];
  assign O_HS_ACK    = ack[REQ_HS];
  assign O_CPU_WAITn = ~I_CPU_REQ | O_CPU_ACK;
endmodule
